inst_loader_mem: RTL and testbench
==================================

Name: inst_loader_mem

Overview:
- Instruction-side memory that sits directly upstream of the CPU core: it serves `inst_din` for the word-addressed PC presented on `inst_aout`.
- It also contains a byte-stream loader FSM that fills the instruction RAM from an external valid/ready byte source (UART/debug bridge).
- While loading, and until a valid image is present, it holds the CPU in reset.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words in the RAM.
- ADDR_W, 10, index width; must satisfy 2^ADDR_W == DEPTH.
- NOP_WORD, 32'h00000013, word returned for out-of-range fetches.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ld_start  in  1  one-cycle pulse: begin (or restart) an image load.
- ld_valid  in  1  byte source has a byte on ld_data.
- ld_data  in  8  image byte.
- ld_ready  out  1  loader accepts a byte this cycle.
- inst_aout  in  32  word-addressed fetch address from the CPU PC.
- inst_din  out  32  instruction word to the CPU.
- cpu_reset  out  1  active-high reset to the CPU core.
- busy  out  1  loader is in a load state.
- done  out  1  one-cycle pulse when an image completes.
- err  out  1  image length exceeded DEPTH; sticky until the next ld_start.
- word_count  out  ADDR_W+1  number of words in the last accepted image.

Behaviour:
- Reset (reset==0, asynchronous) forces:
  - state=IDLE, cpu_reset=1, ld_ready=0, busy=0, done=0, err=0, word_count=0.
  - All internal counters and the byte shift register cleared.
  - RAM contents are not cleared.
- Reset asserted mid-load abandons the load. The partially written RAM is retained, but cpu_reset stays 1 until a later load completes.
- Fetch path is combinational (zero latency), because the CPU decodes inst_din in the same cycle the PC is presented:
  - inst_din = RAM[inst_aout[ADDR_W-1:0]] when inst_aout[31:ADDR_W]==0.
  - Otherwise inst_din = NOP_WORD.
- Byte handshake: a byte transfers on a posedge where ld_valid && ld_ready. ld_ready depends only on state, never on ld_valid.
- ld_ready=1 exactly in states LEN0, LEN1 and DATA. busy equals ld_ready.
- States and transitions:
  - IDLE: cpu_reset=1. ld_start -> LEN0.
  - LEN0: accept the low length byte -> LEN1.
  - LEN1: accept the high byte, giving len={hi,lo} (16-bit word count).
    - len==0 -> RUN; word_count=0; done pulses.
    - len>DEPTH -> ERR; err=1.
    - Otherwise -> DATA; waddr=0, byte_cnt=0.
  - DATA: bytes arrive little-endian, 4 per word.
    - On the 4th byte, RAM[waddr] is written with {byte3,byte2,byte1,byte0} in that same posedge. Then waddr increments and byte_cnt wraps to 0.
    - When the word written is number len (waddr==len-1) -> RUN; word_count=len.
  - RUN: cpu_reset=0 from the first cycle in RUN. done=1 for exactly the first RUN cycle. ld_start -> LEN0 with cpu_reset=1 in the next cycle.
  - ERR: cpu_reset=1, ld_ready=0, err=1. ld_start -> LEN0 and clears err.
- ld_start while in LEN0/LEN1/DATA restarts at LEN0: counters are cleared and any byte offered in that cycle is discarded. ld_start has priority over a byte transfer.
- cpu_reset is registered and is 1 in every state except RUN.
- Gaps in ld_valid are permitted at any byte position; the shift register holds its value across gaps.
- len==DEPTH is legal and fills the RAM exactly; waddr must not wrap.
- Bytes offered outside LEN0/LEN1/DATA are not accepted (ld_ready=0).

Test Plan:
- Reset then idle: after reset release, cpu_reset=1, ld_ready=0. With inst_aout=0x400, inst_din=0x00000013 (out of range).
- Load 2 words: ld_start, then bytes 02 00 | 93 00 10 00 | 13 01 20 00 with ld_valid held.
  - Expect done pulse and cpu_reset=0 the cycle after the last byte.
  - Expect word_count=2.
  - inst_aout=0 -> 0x00100093; inst_aout=1 -> 0x00200113.
- Gapped stream: same image with ld_valid toggling 1,0,0,1 per byte -> identical RAM contents and done timing relative to the final accepted byte.
- Length overflow: header 01 04 (len=1025) -> err=1, ld_ready=0, cpu_reset stays 1. A following ld_start clears err and returns to LEN0.
- Zero length and restart:
  - Header 00 00 -> RUN immediately with done; word_count=0.
  - Then ld_start mid-DATA (after 6 bytes of a len=3 image), followed by a full len=1 image -> only RAM[0] is updated by the restarted image; word_count=1.
- Reload from RUN and async reset:
  - ld_start in RUN -> cpu_reset=1 next cycle.
  - Asserting reset between posedges during DATA forces state IDLE, busy=0 and cpu_reset=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_loader_mem.sv
// Instruction RAM with combinational fetch port and a byte-stream image loader.
// The CPU is held in reset until a complete image has been written.
module inst_loader_mem #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic [31:0]       inst_aout,
  output logic [31:0]       inst_din,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              cpu_reset_q, done_q, err_q;
  logic              accept;
  logic              we;
  logic [15:0]       len_w;
  logic [15:0]       waddr_ext;

  logic [31:0]       mem_q [DEPTH];

  assign ld_ready   = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign busy       = ld_ready;
  assign accept     = ld_valid && ld_ready;
  assign len_w      = {ld_data, len_lo_q};
  assign waddr_ext  = {{(15 - ADDR_W){1'b0}}, waddr_q};
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

  // Zero-latency fetch: the core decodes in the same cycle it drives the PC.
  assign inst_din = (inst_aout[31:ADDR_W] == '0) ? mem_q[inst_aout[ADDR_W-1:0]] : NOP_WORD;

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    waddr_d      = waddr_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_count_d = word_count_q;
    we           = 1'b0;
    if (ld_start) begin
      // Restart wins over any byte offered in the same cycle.
      state_d    = LEN0;
      len_lo_d   = '0;
      len_d      = '0;
      waddr_d    = '0;
      byte_cnt_d = '0;
      shift_d    = '0;
    end else begin
      case (state_q)
        LEN0: if (accept) begin
          len_lo_d = ld_data;
          state_d  = LEN1;
        end
        LEN1: if (accept) begin
          len_d = len_w;
          if (len_w == 16'd0) begin
            state_d      = RUN;
            word_count_d = '0;
          end else if (len_w > 16'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            waddr_d    = '0;
            byte_cnt_d = '0;
          end
        end
        DATA: if (accept) begin
          shift_d    = {ld_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we      = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (waddr_ext == len_q - 16'd1) begin
              state_d      = RUN;
              word_count_d = len_q[ADDR_W:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      waddr_q      <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_count_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      waddr_q      <= waddr_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_count_q <= word_count_d;
      cpu_reset_q  <= (state_d != RUN);
      done_q       <= (state_d == RUN) && (state_q != RUN);
      err_q        <= (state_d == ERR);
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr_q[ADDR_W-1:0]] <= {ld_data, shift_q};
    end
  end

endmodule

// File: tb/tb_inst_loader_mem.sv
// Directed testbench for inst_loader_mem: load, gaps, overflow, full-depth,
// restart and asynchronous reset scenarios.
module tb_inst_loader_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic [31:0] inst_aout = 32'h0;
  logic [31:0] inst_din;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] word_count;

  int vectors = 0;
  int errors  = 0;

  inst_loader_mem dut (
    .clock      (clock),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .inst_aout  (inst_aout),
    .inst_din   (inst_din),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    ld_valid = 1'b0;
    repeat (gap) step();
    ld_valid = 1'b1;
    ld_data  = b;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string name);
    inst_aout = a;
    #1;
    vectors++;
    if (inst_din !== exp) begin
      errors++;
      $display("FAIL %s addr=%h got=%h want=%h", name, a, inst_din, exp);
    end
    $display("fetch %s addr=%h data=%h", name, a, inst_din);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    vectors++;
    if ({cpu_reset, ld_ready, busy, done, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=10000", {cpu_reset, ld_ready, busy, done, err});
    end
    vectors++;
    if (word_count !== 11'd0) begin
      errors++;
      $display("FAIL reset_word_count got=%0d want=0", word_count);
    end
    fetch(32'h400, 32'h00000013, "reset_oob_nop");
    ld_valid = 1'b1; ld_data = 8'h55;
    step();
    ld_valid = 1'b0;
    vectors++;
    if (ld_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept ready=%b busy=%b want 0/0", ld_ready, busy);
    end
  endtask

  task automatic test_load();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    pulse_start();
    vectors++;
    if (ld_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_ready ready=%b busy=%b want 1/1", ld_ready, busy);
    end
    for (int i = 0; i < 9; i++) send_byte(img[i], 0);
    vectors++;
    if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL load_pre_last done=%b cpu_reset=%b want 0/1", done, cpu_reset);
    end
    send_byte(img[9], 0);
    vectors++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done done=%b cpu_reset=%b ready=%b want 1/0/0", done, cpu_reset, ld_ready);
    end
    vectors++;
    if (word_count !== 11'd2) begin
      errors++;
      $display("FAIL load_word_count got=%0d want=2", word_count);
    end
    step();
    vectors++;
    if (done !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse done=%b cpu_reset=%b want 0/0", done, cpu_reset);
    end
    fetch(32'h0, 32'h00100093, "load_w0");
    fetch(32'h1, 32'h00200113, "load_w1");
    fetch(32'h80000001, 32'h00000013, "load_high_nop");
  endtask

  task automatic test_gapped();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'h0B};
    int gaps [10] = '{0, 2, 2, 0, 0, 2, 2, 0, 0, 2};
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(img[i], gaps[i]);
    ld_valid = 1'b0;
    step();
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold done=%b busy=%b want 0/1", done, busy);
    end
    send_byte(img[9], 0);
    vectors++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || word_count !== 11'd2) begin
      errors++;
      $display("FAIL gap_done done=%b cpu_reset=%b wc=%0d want 1/0/2", done, cpu_reset, word_count);
    end
    fetch(32'h0, 32'hCAFEF00D, "gap_w0");
    fetch(32'h1, 32'h0BADBEEF, "gap_w1");
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    vectors++;
    if (err !== 1'b1 || ld_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err err=%b ready=%b cpu_reset=%b done=%b want 1/0/1/0", err, ld_ready, cpu_reset, done);
    end
    send_byte(8'h77, 0);
    vectors++;
    if (err !== 1'b1 || word_count !== 11'd2) begin
      errors++;
      $display("FAIL ovf_sticky err=%b wc=%0d want 1/2", err, word_count);
    end
    pulse_start();
    vectors++;
    if (err !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear err=%b ready=%b want 0/1", err, ld_ready);
    end
    // Full-depth image: len = 1024 must be accepted and must not wrap.
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    vectors++;
    if (err !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL depth_accept err=%b ready=%b want 0/1", err, ld_ready);
    end
    for (int i = 0; i < 1024; i++) begin
      w = 32'h5A000000 + 32'(i);
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
      send_byte(w[23:16], 0);
      send_byte(w[31:24], 0);
    end
    vectors++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || word_count !== 11'd1024) begin
      errors++;
      $display("FAIL depth_done done=%b cpu_reset=%b wc=%0d want 1/0/1024", done, cpu_reset, word_count);
    end
    fetch(32'd0, 32'h5A000000, "depth_first");
    fetch(32'd512, 32'h5A000200, "depth_mid");
    fetch(32'd1023, 32'h5A0003FF, "depth_last");
    fetch(32'd1024, 32'h00000013, "depth_oob");
  endtask

  task automatic test_zero_restart();
    logic [7:0] part [8] = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [7:0] img [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    vectors++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || word_count !== 11'd0) begin
      errors++;
      $display("FAIL zero_len done=%b cpu_reset=%b wc=%0d want 1/0/0", done, cpu_reset, word_count);
    end
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(part[i], 0);
    fetch(32'd0, 32'hDDCCBBAA, "restart_partial_w0");
    // Restart with a byte offered in the same cycle; that byte is discarded.
    ld_valid = 1'b1;
    ld_data  = 8'h33;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    vectors++;
    if (done !== 1'b1 || word_count !== 11'd1) begin
      errors++;
      $display("FAIL restart_done done=%b wc=%0d want 1/1", done, word_count);
    end
    fetch(32'd0, 32'h12345678, "restart_w0");
    fetch(32'd1, 32'h5A000001, "restart_w1_kept");
    fetch(32'd2, 32'h5A000002, "restart_w2_kept");
  endtask

  task automatic test_reload_reset();
    pulse_start();
    vectors++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_cpu_reset cpu_reset=%b busy=%b want 1/1", cpu_reset, busy);
    end
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1 || ld_ready !== 1'b0 || word_count !== 11'd0) begin
      errors++;
      $display("FAIL async_reset busy=%b cpu_reset=%b ready=%b wc=%0d want 0/1/0/0", busy, cpu_reset, ld_ready, word_count);
    end
    step();
    reset = 1'b1;
    step();
    vectors++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle cpu_reset=%b busy=%b want 1/0", cpu_reset, busy);
    end
    fetch(32'd0, 32'h12345678, "reset_ram_kept");
  endtask

  initial begin
    test_reset();
    $display("done test_reset");
    test_load();
    $display("done test_load");
    test_gapped();
    $display("done test_gapped");
    test_overflow();
    $display("done test_overflow");
    test_zero_restart();
    $display("done test_zero_restart");
    test_reload_reset();
    $display("done test_reload_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
